// File: rtl/evm_booth_scheduler.sv
// Booth scheduler: powers the evm, grants it to check-in desks round-robin,
// supervises each vote with start/vote timeouts and closes the session.
module evm_booth_scheduler #(
  parameter int NUM_DESKS     = 4,
  parameter int CNT_W         = 8,
  parameter int SETTLE_CYC    = 2,
  parameter int START_TIMEOUT = 4,
  parameter int VOTE_TIMEOUT  = 120
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 poll_open,
  input  logic                 close_poll,
  input  logic [NUM_DESKS-1:0] desk_req,
  input  logic                 evm_voting_in_progress,
  input  logic                 evm_voting_done,
  output logic                 switch_on_evm,
  output logic                 candidate_ready,
  output logic                 voting_session_done,
  output logic [NUM_DESKS-1:0] desk_grant,
  output logic [NUM_DESKS-1:0] desk_ack,
  output logic [NUM_DESKS-1:0] desk_abort,
  output logic [2:0]           active_desk,
  output logic [CNT_W-1:0]     voters_served,
  output logic [CNT_W-1:0]     timeout_count,
  output logic                 poll_closed
);

  typedef enum logic [3:0] {
    S_OFF, S_SETTLE, S_READY, S_GRANT, S_WAIT_START,
    S_WAIT_VOTE, S_DONE, S_ABORT, S_CLOSING, S_CLOSED
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] START_LAST  = 8'(START_TIMEOUT - 1);
  localparam logic [7:0] VOTE_LAST   = 8'(VOTE_TIMEOUT - 1);

  state_t state, state_n;
  logic [7:0] timer;
  logic [2:0] rr_ptr;
  logic [2:0] win;
  logic       any_req;
  logic       close_pend;
  logic [7:0] req8;
  logic [NUM_DESKS-1:0] desk_oh;

  function automatic logic [2:0] rr_idx(input logic [2:0] base, input int off);
    int j;
    j = int'(base) + off;
    if (j >= NUM_DESKS) j = j - NUM_DESKS;
    return 3'(j);
  endfunction

  assign req8 = 8'(desk_req);

  // Walk downward so the nearest desk after the last grant wins.
  always_comb begin
    win     = rr_ptr;
    any_req = 1'b0;
    for (int i = NUM_DESKS; i >= 1; i--) begin
      if (req8[rr_idx(rr_ptr, i)]) begin
        win     = rr_idx(rr_ptr, i);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_OFF:        if (poll_open) state_n = S_SETTLE;
      S_SETTLE:     if (timer >= SETTLE_LAST) state_n = S_READY;
      S_READY: begin
        if (close_pend)   state_n = S_CLOSING;
        else if (any_req) state_n = S_GRANT;
      end
      S_GRANT:      state_n = S_WAIT_START;
      S_WAIT_START: begin
        if (evm_voting_in_progress)   state_n = S_WAIT_VOTE;
        else if (timer >= START_LAST) state_n = S_ABORT;
      end
      S_WAIT_VOTE: begin
        if (!evm_voting_in_progress) state_n = S_DONE;
        else if (timer >= VOTE_LAST) state_n = S_ABORT;
      end
      S_DONE:       state_n = S_READY;
      S_ABORT:      state_n = S_READY;
      S_CLOSING:    if (evm_voting_done) state_n = S_CLOSED;
      S_CLOSED:     if (!poll_open) state_n = S_OFF;
      default:      state_n = S_OFF;
    endcase
    if (!poll_open && state != S_OFF) state_n = S_OFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_OFF;
      timer         <= '0;
      rr_ptr        <= '0;
      active_desk   <= '0;
      close_pend    <= 1'b0;
      voters_served <= '0;
      timeout_count <= '0;
    end else begin
      state <= state_n;
      if (state_n != state)
        timer <= '0;
      else if (state inside {S_SETTLE, S_WAIT_START, S_WAIT_VOTE})
        timer <= timer + 8'd1;
      if (state == S_READY && state_n == S_GRANT)
        active_desk <= win;
      if (state == S_GRANT)
        rr_ptr <= active_desk;
      if (state == S_OFF && state_n == S_SETTLE) begin
        close_pend    <= 1'b0;
        voters_served <= '0;
        timeout_count <= '0;
      end else begin
        if (state != S_OFF && close_poll)
          close_pend <= 1'b1;
        if (state == S_DONE && !(&voters_served))
          voters_served <= voters_served + CNT_W'(1);
        if (state == S_ABORT && !(&timeout_count))
          timeout_count <= timeout_count + CNT_W'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_DESKS; i++)
      desk_oh[i] = (active_desk == 3'(i));
  end

  assign switch_on_evm       = (state != S_OFF);
  assign candidate_ready     = (state == S_GRANT);
  assign voting_session_done = (state == S_CLOSING);
  assign poll_closed         = (state == S_CLOSED);
  assign desk_grant = (state == S_GRANT) ? desk_oh : '0;
  assign desk_ack   = (state == S_DONE)  ? desk_oh : '0;
  assign desk_abort = (state == S_ABORT) ? desk_oh : '0;

endmodule

// File: tb/tb_evm_booth_scheduler.sv
// Scoreboard bench for evm_booth_scheduler with a behavioural evm and
// desk models; strobes are checked in order against hand-computed events.
module tb_evm_booth_scheduler;

  localparam int ND = 4;

  logic clk, rst, poll_open, close_poll;
  logic [ND-1:0] desk_req;
  logic evm_voting_in_progress, evm_voting_done;
  logic switch_on_evm, candidate_ready, voting_session_done;
  logic [ND-1:0] desk_grant, desk_ack, desk_abort;
  logic [2:0] active_desk;
  logic [7:0] voters_served, timeout_count;
  logic poll_closed;

  evm_booth_scheduler dut (
    .clk(clk), .rst(rst), .poll_open(poll_open), .close_poll(close_poll),
    .desk_req(desk_req),
    .evm_voting_in_progress(evm_voting_in_progress),
    .evm_voting_done(evm_voting_done),
    .switch_on_evm(switch_on_evm), .candidate_ready(candidate_ready),
    .voting_session_done(voting_session_done),
    .desk_grant(desk_grant), .desk_ack(desk_ack), .desk_abort(desk_abort),
    .active_desk(active_desk), .voters_served(voters_served),
    .timeout_count(timeout_count), .poll_closed(poll_closed)
  );

  typedef struct {
    int kind;   // 0 grant, 1 ack, 2 abort
    int desk;
    int delta;  // cycles since previous grant, -1 = unchecked
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_g = 0;
  int hold_len = 10;
  int issued[ND];
  int granted[ND];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  always_comb begin
    for (int i = 0; i < ND; i++) desk_req[i] = (issued[i] > granted[i]);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input int k, input int d, input int dl);
    exp_t e;
    e.kind = k;
    e.desk = d;
    e.delta = dl;
    q.push_back(e);
  endtask

  task automatic wait_empty(input string name, input int maxc);
    int n = 0;
    while (q.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s pending=%0d required=0", name, q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_prog(input logic v, input int maxc);
    int n = 0;
    while (evm_voting_in_progress !== v && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("wait_in_progress", evm_voting_in_progress, v);
  endtask

  // evm model: in_progress rises one cycle after the strobe, lasts hold_len
  initial begin
    evm_voting_in_progress = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && candidate_ready && hold_len > 0) begin
        @(negedge clk);
        evm_voting_in_progress = 1'b1;
        repeat (hold_len) @(negedge clk);
        evm_voting_in_progress = 1'b0;
      end
    end
  end

  // monitor: pops one expected event per strobe
  initial begin
    exp_t e;
    logic [ND-1:0] vec;
    int kind, idx;
    for (int i = 0; i < ND; i++) granted[i] = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (|{desk_grant, desk_ack, desk_abort}) begin
          idx = 0;
          if (desk_grant != 0) begin kind = 0; vec = desk_grant; end
          else if (desk_ack != 0) begin kind = 1; vec = desk_ack; end
          else begin kind = 2; vec = desk_abort; end
          for (int i = 0; i < ND; i++) if (vec[i]) idx = i;
          chk("strobe_excl", $countones({desk_grant, desk_ack, desk_abort}), 1);
          chk("cand_vs_grant", candidate_ready, 32'(kind == 0));
          if (kind == 0) chk("grant_during_vote", evm_voting_in_progress, 0);
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_strobe kind=%0d desk=%0d required=none",
                     kind, idx);
          end else begin
            e = q.pop_front();
            chk("strobe_kind", kind, e.kind);
            chk("strobe_desk", vec, 32'(1) << e.desk);
            if (e.delta >= 0) chk("strobe_delay", cyc - last_g, e.delta);
          end
          if (kind == 0) begin
            last_g = cyc;
            granted[idx]++;
          end
        end else begin
          chk("cand_idle", candidate_ready, 0);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    poll_open = 1'b0;
    close_poll = 1'b0;
    evm_voting_done = 1'b0;
    for (int i = 0; i < ND; i++) issued[i] = 0;
    repeat (2) @(negedge clk);
    chk("rst_switch", switch_on_evm, 0);
    chk("rst_cand", candidate_ready, 0);
    chk("rst_grant", desk_grant, 0);
    chk("rst_served", voters_served, 0);
    chk("rst_tmo", timeout_count, 0);
    chk("rst_active", active_desk, 0);
    chk("rst_closed", poll_closed, 0);
    chk("rst_sess", voting_session_done, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("off_switch", switch_on_evm, 0);

    // single voter at desk 0 (search starts at 1 and wraps)
    hold_len = 10;
    push(0, 0, -1);
    push(1, 0, 12);
    issued[0] = 1;
    poll_open = 1'b1;
    @(negedge clk);
    chk("settle_switch", switch_on_evm, 1);
    repeat (2) @(negedge clk);
    chk("ready_no_grant", desk_grant, 0);
    @(negedge clk);
    chk("first_grant", desk_grant, 4'b0001);
    chk("first_cand", candidate_ready, 1);
    wait_empty("t1_events", 60);
    chk("t1_served", voters_served, 1);

    // all desks, two voters each: rotation from desk 1
    for (int i = 0; i < ND; i++) issued[i] += 2;
    for (int k = 0; k < 8; k++) begin
      push(0, (k + 1) % ND, (k == 0) ? -1 : 14);
      push(1, (k + 1) % ND, 12);
    end
    wait_empty("t2_events", 300);
    chk("t2_served", voters_served, 9);
    chk("t2_tmo", timeout_count, 0);

    // evm never starts: start timeout for desks 1 and 2
    hold_len = 0;
    issued[1]++;
    issued[2]++;
    push(0, 1, -1);
    push(2, 1, 5);
    push(0, 2, 7);
    push(2, 2, 5);
    wait_empty("t3_events", 60);
    chk("t3_tmo", timeout_count, 2);
    chk("t3_served", voters_served, 9);

    // vote held for 200 cycles: vote timeout
    hold_len = 200;
    issued[3]++;
    push(0, 3, -1);
    push(2, 3, 122);
    wait_empty("t4_events", 200);
    chk("t4_tmo", timeout_count, 3);
    chk("t4_served", voters_served, 9);
    wait_prog(1'b0, 150);

    // close mid-vote with every desk waiting
    hold_len = 10;
    for (int i = 0; i < ND; i++) issued[i] += 3;
    push(0, 0, -1);
    push(1, 0, 12);
    wait_prog(1'b1, 20);
    close_poll = 1'b1;
    @(negedge clk);
    close_poll = 1'b0;
    for (int n = 0; n < 40 && voting_session_done !== 1'b1; n++)
      @(negedge clk);
    chk("close_pending_events", q.size(), 0);
    for (int k = 0; k < 5; k++) begin
      chk("sess_done_held", voting_session_done, 1);
      chk("not_closed_yet", poll_closed, 0);
      @(negedge clk);
    end
    evm_voting_done = 1'b1;
    @(negedge clk);
    evm_voting_done = 1'b0;
    chk("poll_closed", poll_closed, 1);
    chk("sess_done_off", voting_session_done, 0);
    chk("t5_served", voters_served, 10);
    repeat (5) @(negedge clk);
    for (int i = 0; i < ND; i++) issued[i] = granted[i];

    // counters retained while off, cleared on settle
    poll_open = 1'b0;
    @(negedge clk);
    chk("off_switch2", switch_on_evm, 0);
    chk("off_closed", poll_closed, 0);
    repeat (3) @(negedge clk);
    chk("off_keep_served", voters_served, 10);
    chk("off_keep_tmo", timeout_count, 3);
    poll_open = 1'b1;
    @(negedge clk);
    chk("settle_clr_served", voters_served, 0);
    chk("settle_clr_tmo", timeout_count, 0);

    // poll_open dropped during a vote: no ack for that voter
    issued[1]++;
    issued[2]++;
    push(0, 1, -1);
    push(1, 1, 12);
    push(0, 2, 14);
    wait_empty("t6_events", 60);
    wait_prog(1'b1, 10);
    @(negedge clk);
    poll_open = 1'b0;
    @(negedge clk);
    chk("drop_switch", switch_on_evm, 0);
    chk("drop_cand", candidate_ready, 0);
    chk("drop_served", voters_served, 1);
    wait_prog(1'b0, 20);
    poll_open = 1'b1;
    @(negedge clk);
    chk("reopen_served", voters_served, 0);

    // asynchronous reset between clock edges
    repeat (3) @(negedge clk);
    chk("pre_rst_switch", switch_on_evm, 1);
    chk("pre_rst_active", active_desk, 2);
    rst = 1'b1;
    #1;
    chk("async_rst_switch", switch_on_evm, 0);
    chk("async_rst_active", active_desk, 0);
    @(negedge clk);
    chk("final_queue", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
